// File: rtl/tlc_tod_if.sv
// Time-of-day bus between the traffic light controller and tlc_tod_clock:
// count/load controls in one direction, BCD time, peak and strobes in the other.
interface tlc_tod_if;
    logic       ena;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       load_pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       peak;
    logic       sec_tick;
    logic       load_err;

    modport master (
        output ena, load, load_hh, load_mm, load_ss, load_pm,
        input  hh, mm, ss, pm, peak, sec_tick, load_err
    );

    modport slave (
        input  ena, load, load_hh, load_mm, load_ss, load_pm,
        output hh, mm, ss, pm, peak, sec_tick, load_err
    );
endinterface

// File: rtl/tlc_tod_clock.sv
// 12-hour BCD time-of-day clock with prescaler, time load and peak-hour decode
// for the traffic light controller.
module tlc_tod_clock #(
    parameter int         TICKS_PER_SEC = 1,
    parameter logic [7:0] PEAK_AM_START = 8'h08,
    parameter logic [7:0] PEAK_AM_END   = 8'h10,
    parameter logic [7:0] PEAK_PM_START = 8'h05,
    parameter logic [7:0] PEAK_PM_END   = 8'h07
) (
    input logic       clk,
    input logic       reset,
    tlc_tod_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic [7:0]    hh;
    logic [7:0]    mm;
    logic [7:0]    ss;
    logic          pm;
    logic          sec_tick;
    logic          load_err;

    logic          wrap;
    logic          load_ok;
    logic [7:0]    hh_nxt;
    logic [7:0]    mm_nxt;
    logic [7:0]    ss_nxt;
    logic          pm_nxt;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign wrap = bus.ena && (presc == PRESC_LAST);

    assign load_ok = bcd_ok(bus.load_hh, 8'h12) && (bus.load_hh != 8'h00) &&
                     bcd_ok(bus.load_mm, 8'h59) &&
                     bcd_ok(bus.load_ss, 8'h59);

    // One-second advance of the current time, with carries rippling ss -> mm -> hh -> pm
    always_comb begin
        ss_nxt = ss;
        mm_nxt = mm;
        hh_nxt = hh;
        pm_nxt = pm;
        if (ss == 8'h59) begin
            ss_nxt = 8'h00;
            if (mm == 8'h59) begin
                mm_nxt = 8'h00;
                if (hh == 8'h12) begin
                    hh_nxt = 8'h01;
                end else begin
                    hh_nxt = bcd_inc(hh);
                    if (hh == 8'h11)
                        pm_nxt = ~pm;
                end
            end else begin
                mm_nxt = bcd_inc(mm);
            end
        end else begin
            ss_nxt = bcd_inc(ss);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            hh       <= 8'h12;
            mm       <= 8'h00;
            ss       <= 8'h00;
            pm       <= 1'b0;
            sec_tick <= 1'b0;
            load_err <= 1'b0;
        end else if (bus.load && load_ok) begin
            presc    <= '0;
            hh       <= bus.load_hh;
            mm       <= bus.load_mm;
            ss       <= bus.load_ss;
            pm       <= bus.load_pm;
            sec_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            // A rejected load still lets a due second advance go through
            load_err <= bus.load;
            sec_tick <= wrap;
            if (bus.ena)
                presc <= wrap ? '0 : presc + 1'b1;
            if (wrap) begin
                hh <= hh_nxt;
                mm <= mm_nxt;
                ss <= ss_nxt;
                pm <= pm_nxt;
            end
        end
    end

    assign bus.hh       = hh;
    assign bus.mm       = mm;
    assign bus.ss       = ss;
    assign bus.pm       = pm;
    assign bus.sec_tick = sec_tick;
    assign bus.load_err = load_err;
    assign bus.peak     = (!pm && (hh >= PEAK_AM_START) && (hh <= PEAK_AM_END)) ||
                          ( pm && (hh >= PEAK_PM_START) && (hh <= PEAK_PM_END));

endmodule
